led_fader: RTL and testbench
============================

# led_fader

Downstream stage of the blink divider: consumes its square-wave LED level and drives the physical LED pin with a PWM-dimmed, linearly ramped ("breathing") version. A rising level fades the LED up, a falling level fades it down. Reversals mid-ramp continue from the current brightness. Sits between the divider's output and the board LED pad.

## Interface
- PWM_BITS, 8, width of duty and PWM counter; PWM period = 2**PWM_BITS clocks
- MAX_DUTY, 2**PWM_BITS-1, duty at which a rising ramp stops (1..2**PWM_BITS-1)
- STEP_CYCLES, 78_431, clocks per duty step (~200 ms full ramp at 100 MHz, 8 bits); must be >= 1
- clk  in  1  system clock (100 MHz)
- reset_n  in  1  asynchronous, active-low reset
- level_in  in  1  target LED level from the divider, synchronous to clk
- led_out  out  1  PWM drive to the LED pad, registered
- duty  out  PWM_BITS  current linear duty, registered
- busy  out  1  high in RISE or FALL

## Operation
- States: OFF, RISE, ON, FALL.
- OFF: duty=0. level_in=1 -> RISE.
- RISE: on each step tick, duty+1. If the tick makes duty==MAX_DUTY -> ON in the same cycle. level_in=0 -> FALL, with duty held.
- ON: duty=MAX_DUTY. level_in=0 -> FALL.
- FALL: on each step tick, duty-1. If the tick makes duty==0 -> OFF. level_in=1 -> RISE, with duty held.
- Step counter: $clog2(STEP_CYCLES)+1 bits. Counts only in RISE/FALL. Cleared on every state change and in OFF/ON. Tick when count==STEP_CYCLES-1; count then wraps to 0.
- PWM counter: PWM_BITS wide, free-running 0..2**PWM_BITS-1 and wrapping. Runs in all states.
- Compare: led_out_next = (duty_eff > pwm_cnt). duty_eff=0 gives constant low. Max duty 2**PWM_BITS-1 gives high for 2**PWM_BITS-1 of every 2**PWM_BITS clocks.
- No saturation logic is needed: the transitions keep duty within 0..MAX_DUTY.
- level_in is in the clk domain; no synchroniser.

## Timing
- Reset values: state=OFF, duty=0, step count=0, pwm_cnt=0, led_out=0, busy=0.
- Reset is asynchronous and mid-ramp: all registers return to reset values immediately. Fading resumes only from OFF.
- State reacts to level_in in the cycle after it changes. busy rises 1 clock after level_in rises from OFF.
- First duty change occurs STEP_CYCLES clocks after entering RISE/FALL. Full ramp 0->MAX_DUTY = MAX_DUTY*STEP_CYCLES clocks.
- led_out lags duty/pwm_cnt by 1 clock (registered compare).
- Simultaneous events:
  - level_in falls on the tick that would reach MAX_DUTY: the reversal wins. FALL is entered, the duty increment is discarded, and the counter is cleared.
  - The same rule applies symmetrically in FALL.
- If level_in toggles every cycle, state alternates RISE/FALL and duty never changes.

## Configuration
- LED_FADER_GAMMA_EN defined: duty_eff = (duty*duty) >> PWM_BITS, for a perceptual (square-law) fade. The product is 2*PWM_BITS wide. This is combinational and adds no latency.
- Not defined: duty_eff = duty (linear).
- The duty port always reports linear duty.

## Structure
- Package led_pkg: typedef enum logic [1:0] fader_state_t {OFF, RISE, ON, FALL}, and localparam DEFAULT_STEP_CYCLES = 78_431.
- Sub-module pwm_gen (params PWM_BITS):
  - contains the free-running counter and the registered comparator;
  - inputs clk, reset_n, duty_eff; output pwm_out.
- led_fader holds the FSM, the step counter and the gamma mapping.

## Test plan
Use PWM_BITS=4, MAX_DUTY=15, STEP_CYCLES=4, gamma off unless stated.
- Hold reset_n=0 with level_in=1 -> led_out=0, duty=0, busy=0. Release -> busy=1 next cycle, duty=1 four clocks later.
- level_in=1 held -> duty reaches 15 after 60 clocks, busy drops and state is ON. led_out is high 15 of every 16 clocks.
- Rise to duty=7, then level_in=0 -> duty holds 7, then decrements every 4 clocks to 0, state OFF, led_out constant 0.
- Drop level_in on the exact tick where duty would go 14->15 -> duty stays 14, FALL entered, next change to 13 four clocks later.
- Assert reset_n=0 asynchronously (between clock edges) at duty=9 -> duty and led_out go 0 immediately. After release with level_in=1, the ramp restarts from 0.
- With LED_FADER_GAMMA_EN, duty=8 -> duty_eff=4, and led_out is high 4 of every 16 clocks.

Source files
------------

// File: rtl/led_pkg.sv
// Shared types and defaults for the LED fader.
// Imported by led_fader and its testbench.
package led_pkg;

    typedef enum logic [1:0] {
        OFF  = 2'd0,
        RISE = 2'd1,
        ON   = 2'd2,
        FALL = 2'd3
    } fader_state_t;

    localparam int DEFAULT_STEP_CYCLES = 78_431;

endpackage

// File: rtl/pwm_gen.sv
// Free-running PWM counter with a registered duty compare.
// led pin lags duty/counter by one clock; no backpressure.
module pwm_gen #(
    parameter int PWM_BITS = 8
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic [PWM_BITS-1:0] duty_eff,
    output logic                pwm_out
);

    logic [PWM_BITS-1:0] cnt_q;
    logic                pwm_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= '0;
            pwm_q <= 1'b0;
        end else begin
            cnt_q <= cnt_q + PWM_BITS'(1);
            // Strict compare: duty 0 never lights, full scale stays dark one slot.
            pwm_q <= (duty_eff > cnt_q);
        end
    end

    assign pwm_out = pwm_q;

endmodule

// File: rtl/led_fader.sv
// Breathing LED: ramps PWM duty up/down following the divider's level.
// Optional square-law brightness map when LED_FADER_GAMMA_EN is defined.
module led_fader
    import led_pkg::*;
#(
    parameter int PWM_BITS    = 8,
    parameter int MAX_DUTY    = (1 << PWM_BITS) - 1,
    parameter int STEP_CYCLES = DEFAULT_STEP_CYCLES
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                level_in,
    output logic                led_out,
    output logic [PWM_BITS-1:0] duty,
    output logic                busy
);

    localparam int                 CW       = $clog2(STEP_CYCLES) + 1;
    localparam logic [CW-1:0]       TICK_AT  = CW'(STEP_CYCLES - 1);
    localparam logic [PWM_BITS-1:0] MAX_D    = PWM_BITS'(MAX_DUTY);

    fader_state_t        state_q;
    logic [PWM_BITS-1:0] duty_q;
    logic [CW-1:0]       step_cnt_q;
    logic                busy_q;

    logic                step_tick;
    logic [CW-1:0]       step_cnt_inc;
    logic [PWM_BITS-1:0] duty_inc;
    logic [PWM_BITS-1:0] duty_dec;
    logic [PWM_BITS-1:0] duty_eff;

    assign step_tick    = (step_cnt_q == TICK_AT);
    assign step_cnt_inc = step_cnt_q + CW'(1);
    assign duty_inc     = duty_q + PWM_BITS'(1);
    assign duty_dec     = duty_q - PWM_BITS'(1);

    // A level reversal outranks a coincident step tick: duty is held.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= OFF;
            duty_q     <= '0;
            step_cnt_q <= '0;
            busy_q     <= 1'b0;
        end else begin
            case (state_q)
                OFF: begin
                    duty_q     <= '0;
                    step_cnt_q <= '0;
                    if (level_in) begin
                        state_q <= RISE;
                        busy_q  <= 1'b1;
                    end
                end
                RISE: begin
                    if (!level_in) begin
                        state_q    <= FALL;
                        step_cnt_q <= '0;
                    end else if (step_tick) begin
                        duty_q     <= duty_inc;
                        step_cnt_q <= '0;
                        if (duty_inc == MAX_D) begin
                            state_q <= ON;
                            busy_q  <= 1'b0;
                        end
                    end else begin
                        step_cnt_q <= step_cnt_inc;
                    end
                end
                ON: begin
                    duty_q     <= MAX_D;
                    step_cnt_q <= '0;
                    if (!level_in) begin
                        state_q <= FALL;
                        busy_q  <= 1'b1;
                    end
                end
                FALL: begin
                    if (level_in) begin
                        state_q    <= RISE;
                        step_cnt_q <= '0;
                    end else if (step_tick) begin
                        duty_q     <= duty_dec;
                        step_cnt_q <= '0;
                        if (duty_dec == '0) begin
                            state_q <= OFF;
                            busy_q  <= 1'b0;
                        end
                    end else begin
                        step_cnt_q <= step_cnt_inc;
                    end
                end
                default: begin
                    state_q    <= OFF;
                    duty_q     <= '0;
                    step_cnt_q <= '0;
                    busy_q     <= 1'b0;
                end
            endcase
        end
    end

`ifdef LED_FADER_GAMMA_EN
    logic [2*PWM_BITS-1:0] duty_sq;
    assign duty_sq  = {{PWM_BITS{1'b0}}, duty_q} * {{PWM_BITS{1'b0}}, duty_q};
    assign duty_eff = duty_sq[2*PWM_BITS-1:PWM_BITS];
`else
    assign duty_eff = duty_q;
`endif

    pwm_gen #(
        .PWM_BITS (PWM_BITS)
    ) u_pwm (
        .clk      (clk),
        .reset_n  (reset_n),
        .duty_eff (duty_eff),
        .pwm_out  (led_out)
    );

    assign duty = duty_q;
    assign busy = busy_q;

endmodule

// File: tb/tb_led_fader.sv
// Directed test of led_fader with 4-bit PWM, 4-clock steps.
module tb_led_fader;
    import led_pkg::*;

    logic       clk;
    logic       reset_n;
    logic       level_in;
    logic       led_out;
    logic [3:0] duty;
    logic       busy;

    int errors = 0;
    int checks = 0;
    int highs;

    led_fader #(
        .PWM_BITS    (4),
        .MAX_DUTY    (15),
        .STEP_CYCLES (4)
    ) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .level_in (level_in),
        .led_out  (led_out),
        .duty     (duty),
        .busy     (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int eff(input int d);
`ifdef LED_FADER_GAMMA_EN
        return (d * d) >> 4;
`else
        return d;
`endif
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic count_highs(output int n);
        n = 0;
        for (int i = 0; i < 16; i++) begin
            tick();
            if (led_out === 1'b1) n++;
        end
    endtask

    initial begin
        reset_n  = 1'b0;
        level_in = 1'b1;
        repeat (3) tick();
        check("rst_led",   32'(led_out), 0);
        check("rst_duty",  32'(duty), 0);
        check("rst_busy",  32'(busy), 0);
        check("rst_state", 32'(dut.state_q), 32'(OFF));

        // Release with level high: RISE next clock, first step 4 clocks later.
        reset_n = 1'b1;
        tick();
        check("rise_busy",  32'(busy), 1);
        check("rise_state", 32'(dut.state_q), 32'(RISE));
        check("rise_duty0", 32'(duty), 0);
        repeat (3) tick();
        check("rise_hold",  32'(duty), 0);
        tick();
        check("rise_duty1", 32'(duty), 1);
        repeat (52) tick();
        check("rise_duty14", 32'(duty), 14);
        check("rise_busy14", 32'(busy), 1);
        repeat (4) tick();
        check("on_duty",  32'(duty), 15);
        check("on_busy",  32'(busy), 0);
        check("on_state", 32'(dut.state_q), 32'(ON));
        repeat (2) tick();
        count_highs(highs);
        check("on_highs", 32'(highs), 32'(eff(15)));

        // Fall one step, reverse, then drop exactly on the 14->15 tick.
        level_in = 1'b0;
        tick();
        check("fall_state", 32'(dut.state_q), 32'(FALL));
        check("fall_duty15", 32'(duty), 15);
        repeat (4) tick();
        check("fall_duty14", 32'(duty), 14);
        level_in = 1'b1;
        tick();
        check("rev_state", 32'(dut.state_q), 32'(RISE));
        check("rev_duty",  32'(duty), 14);
        repeat (3) tick();
        check("rev_hold", 32'(duty), 14);
        level_in = 1'b0;
        tick();
        check("clash_duty",  32'(duty), 14);
        check("clash_state", 32'(dut.state_q), 32'(FALL));
        repeat (3) tick();
        check("clash_hold", 32'(duty), 14);
        tick();
        check("clash_13", 32'(duty), 13);
        repeat (51) tick();
        check("fall_duty1", 32'(duty), 1);
        tick();
        check("off_duty",  32'(duty), 0);
        check("off_state", 32'(dut.state_q), 32'(OFF));
        check("off_busy",  32'(busy), 0);
        repeat (2) tick();
        count_highs(highs);
        check("off_highs", 32'(highs), 0);

        // Rise to 7, reverse, then toggle every cycle: duty must freeze.
        level_in = 1'b1;
        tick();
        repeat (28) tick();
        check("mid_duty7", 32'(duty), 7);
        level_in = 1'b0;
        tick();
        check("mid_fall7", 32'(duty), 7);
        for (int i = 0; i < 4; i++) begin
            level_in = ~level_in;
            tick();
        end
        highs = 0;
        for (int i = 0; i < 16; i++) begin
            level_in = ~level_in;
            tick();
            if (led_out === 1'b1) highs++;
        end
        check("tog_duty",  32'(duty), 7);
        check("tog_highs", 32'(highs), 32'(eff(7)));
        check("tog_state", 32'(dut.state_q), 32'(FALL));
        repeat (3) tick();
        check("mid_hold7", 32'(duty), 7);
        tick();
        check("mid_duty6", 32'(duty), 6);
        repeat (24) tick();
        check("mid_off",   32'(duty), 0);
        check("mid_state", 32'(dut.state_q), 32'(OFF));

        // Asynchronous reset between edges at duty 9.
        level_in = 1'b1;
        tick();
        repeat (36) tick();
        check("ar_duty9", 32'(duty), 9);
        #2;
        reset_n = 1'b0;
        #1;
        check("ar_duty",  32'(duty), 0);
        check("ar_led",   32'(led_out), 0);
        check("ar_busy",  32'(busy), 0);
        check("ar_pwm",   32'(dut.u_pwm.cnt_q), 0);
        check("ar_state", 32'(dut.state_q), 32'(OFF));
        tick();
        reset_n = 1'b1;
        tick();
        check("ar_rise",  32'(busy), 1);
        check("ar_dutyr", 32'(duty), 0);
        repeat (4) tick();
        check("ar_duty1", 32'(duty), 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
